// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush, data-memory wait/timeout.
// Define STALL_COUNT_EN to add the saturating STALL_CNT counter of cycles with the PC held.
module hazard_stall_controller #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rs,
  input  logic [2:0]       ID_Use,
  input  logic [3:0]       EX_Rd,
  input  logic             EX_rf,
  input  logic             EX_Load,
  input  logic [3:0]       MEM_Rd,
  input  logic [3:0]       WB_Rd,
  input  logic             MEM_rf,
  input  logic             WB_rf,
  input  logic             BR_Taken,
  input  logic             MEM_BUSY,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IFID_CLR,
  output logic             IDEX_LE,
  output logic             IDEX_BUBBLE,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [1:0]       FWD_C,
  output logic             BUS_FAULT,
`ifdef STALL_COUNT_EN
  output logic [CNT_W-1:0] STALL_CNT,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d, wait_inc;

  logic [3:0] src [3];
  logic [1:0] fwd [3];
  logic       lu;

  logic run_pc_le, run_ifid_le, run_ifid_clr, run_idex_le, run_bubble;
  logic pc_le_c, ifid_le_c, ifid_clr_c, idex_le_c, bubble_c;

  assign src[0] = ID_Rn;
  assign src[1] = ID_Rm;
  assign src[2] = ID_Rs;

  // Youngest producer wins; a load still in EX cannot forward and raises the load-use stall instead.
  always_comb begin
    lu = 1'b0;
    for (int p = 0; p < 3; p++) begin
      fwd[p] = 2'b00;
      if (ID_Use[p] && src[p] != 4'hF) begin
        if (EX_rf && !EX_Load && src[p] == EX_Rd)
          fwd[p] = 2'b01;
        else if (MEM_rf && src[p] == MEM_Rd)
          fwd[p] = 2'b10;
        else if (WB_rf && src[p] == WB_Rd)
          fwd[p] = 2'b11;
        if (EX_rf && EX_Load && src[p] == EX_Rd)
          lu = 1'b1;
      end
    end
  end

  always_comb begin
    run_pc_le    = 1'b1;
    run_ifid_le  = 1'b1;
    run_ifid_clr = 1'b0;
    run_idex_le  = 1'b1;
    run_bubble   = 1'b0;
    if (MEM_BUSY) begin
      run_pc_le   = 1'b0;
      run_ifid_le = 1'b0;
      run_idex_le = 1'b0;
    end else if (lu) begin
      run_pc_le   = 1'b0;
      run_ifid_le = 1'b0;
      run_bubble  = 1'b1;
    end else if (BR_Taken) begin
      run_ifid_clr = 1'b1;
    end
  end

  // A wait that ends this cycle falls straight back onto the RUN rules.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    wait_inc   = (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    pc_le_c    = run_pc_le;
    ifid_le_c  = run_ifid_le;
    ifid_clr_c = run_ifid_clr;
    idex_le_c  = run_idex_le;
    bubble_c   = run_bubble;
    case (state_q)
      ST_RUN: begin
        if (MEM_BUSY) begin
          state_d = ST_MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (MEM_BUSY) begin
          wait_d = wait_inc;
          if (wait_inc >= LIMIT)
            state_d = ST_FAULT;
        end else begin
          state_d = ST_RUN;
          wait_d  = 8'd0;
        end
      end
      ST_FAULT: begin
        pc_le_c    = 1'b0;
        ifid_le_c  = 1'b0;
        ifid_clr_c = 1'b0;
        idex_le_c  = 1'b0;
        bubble_c   = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= ST_RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // While reset is held the outputs present a hazard-free RUN cycle.
  assign PC_LE       = CLR ? pc_le_c    : 1'b1;
  assign IFID_LE     = CLR ? ifid_le_c  : 1'b1;
  assign IFID_CLR    = CLR ? ifid_clr_c : 1'b0;
  assign IDEX_LE     = CLR ? idex_le_c  : 1'b1;
  assign IDEX_BUBBLE = CLR ? bubble_c   : 1'b0;
  assign FWD_A       = CLR ? fwd[0]     : 2'b00;
  assign FWD_B       = CLR ? fwd[1]     : 2'b00;
  assign FWD_C       = CLR ? fwd[2]     : 2'b00;
  assign BUS_FAULT   = CLR && (state_q == ST_FAULT);
  assign dbg_state   = state_q;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)
      stall_q <= '0;
    else if (!PC_LE && stall_q != {CNT_W{1'b1}})
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_stall_controller;
  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [3:0] ID_Rn, ID_Rm, ID_Rs, EX_Rd, MEM_Rd, WB_Rd;
  logic [2:0] ID_Use;
  logic       EX_rf, EX_Load, MEM_rf, WB_rf, BR_Taken, MEM_BUSY;
  logic       PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_BUBBLE, BUS_FAULT;
  logic [1:0] FWD_A, FWD_B, FWD_C, dbg_state;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] STALL_CNT;
`endif

  hazard_stall_controller #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR(CLR),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rs(ID_Rs), .ID_Use(ID_Use),
    .EX_Rd(EX_Rd), .EX_rf(EX_rf), .EX_Load(EX_Load),
    .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd), .MEM_rf(MEM_rf), .WB_rf(WB_rf),
    .BR_Taken(BR_Taken), .MEM_BUSY(MEM_BUSY),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_CLR(IFID_CLR), .IDEX_LE(IDEX_LE),
    .IDEX_BUBBLE(IDEX_BUBBLE), .FWD_A(FWD_A), .FWD_B(FWD_B), .FWD_C(FWD_C),
    .BUS_FAULT(BUS_FAULT),
`ifdef STALL_COUNT_EN
    .STALL_CNT(STALL_CNT),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Scoreboard and reference-model state
  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  int          m_streak    = 0;   // consecutive busy cycles seen
  bit          m_faulted   = 0;
  int          m_stalls    = 0;   // cycles with PC held since reset

  // Vector: PC_LE IFID_LE IFID_CLR IDEX_LE IDEX_BUBBLE FWD_A FWD_B FWD_C BUS_FAULT
  function automatic logic [11:0] dut_outs();
    return {PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_BUBBLE, FWD_A, FWD_B, FWD_C, BUS_FAULT};
  endfunction

  function automatic logic [1:0] model_fwd(input logic use_bit, input logic [3:0] src);
    logic [3:0] rd [3];
    logic       ok [3];
    rd[0] = EX_Rd;  ok[0] = EX_rf && !EX_Load;
    rd[1] = MEM_Rd; ok[1] = MEM_rf;
    rd[2] = WB_Rd;  ok[2] = WB_rf;
    if (!use_bit || src == 4'd15) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (ok[k] && rd[k] == src) return 2'(k + 1);
    return 2'b00;
  endfunction

  function automatic bit model_lu();
    logic [3:0] s [3];
    s[0] = ID_Rn; s[1] = ID_Rm; s[2] = ID_Rs;
    if (!(EX_Load && EX_rf)) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (ID_Use[k] && s[k] != 4'd15 && s[k] == EX_Rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [11:0] model_expect();
    logic pc, ifid, fl, idex, bub;
    if (!CLR) return 12'b1101_0000_0000;
    pc = 1'b1; ifid = 1'b1; fl = 1'b0; idex = 1'b1; bub = 1'b0;
    if (m_faulted || MEM_BUSY) begin
      pc = 1'b0; ifid = 1'b0; idex = 1'b0;
    end else if (model_lu()) begin
      pc = 1'b0; ifid = 1'b0; bub = 1'b1;
    end else if (BR_Taken) begin
      fl = 1'b1;
    end
    return {pc, ifid, fl, idex, bub, model_fwd(ID_Use[0], ID_Rn),
            model_fwd(ID_Use[1], ID_Rm), model_fwd(ID_Use[2], ID_Rs), m_faulted};
  endfunction

  // Finish the current cycle: advance the model across the rising edge.
  task automatic step();
    logic [11:0] e;
    e = model_expect();
    @(posedge CLK);
    if (!CLR) begin
      m_streak = 0; m_faulted = 0; m_stalls = 0;
    end else begin
      if (!e[11] && m_stalls < CNT_MAX) m_stalls++;
      if (!m_faulted) begin
        if (MEM_BUSY) begin
          m_streak++;
          if (m_streak >= WAIT_LIMIT) m_faulted = 1;
        end else begin
          m_streak = 0;
        end
      end
    end
    #1;
  endtask

  // Driver tasks
  task automatic set_idle();
    ID_Rn = 4'd1; ID_Rm = 4'd2; ID_Rs = 4'd3; ID_Use = 3'b000;
    EX_Rd = 4'd0; EX_rf = 1'b0; EX_Load = 1'b0;
    MEM_Rd = 4'd0; MEM_rf = 1'b0; WB_Rd = 4'd0; WB_rf = 1'b0;
    BR_Taken = 1'b0; MEM_BUSY = 1'b0;
  endtask

  function automatic logic [3:0] pick_reg();
    return ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
  endfunction

  task automatic test_reset();
    logic [11:0] got, exp;
    CLR = 1'b0;
    ID_Use = 3'b111; ID_Rn = 4'd5; ID_Rm = 4'd6; ID_Rs = 4'd7;
    EX_Rd = 4'd5; EX_rf = 1'b1; EX_Load = 1'b1; MEM_Rd = 4'd6; MEM_rf = 1'b1;
    WB_Rd = 4'd7; WB_rf = 1'b1; BR_Taken = 1'b1; MEM_BUSY = 1'b1;
    exp_q.push_back(model_expect());
    @(negedge CLK);
    got = dut_outs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_outs: got %b want %b", got, exp); end
    vectors++;
    if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    step();
    CLR = 1'b1;
    ID_Use = 3'b111; ID_Rn = 4'd1; ID_Rm = 4'd2; ID_Rs = 4'd3;
    EX_Rd = 4'd7; EX_rf = 1'b1; EX_Load = 1'b0; MEM_Rd = 4'd8; MEM_rf = 1'b1;
    WB_Rd = 4'd9; WB_rf = 1'b1; BR_Taken = 1'b0; MEM_BUSY = 1'b0;
    exp_q.push_back(model_expect());
    @(negedge CLK);
    got = dut_outs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL release_outs: got %b want %b", got, exp); end
    vectors++;
    if (got !== 12'b1101_0000_0000) begin
      miscompares++; $display("FAIL release_no_hazard: got %b want 110100000000", got);
    end
    step();
  endtask

  task automatic test_forwarding();
    logic [11:0] got, exp;
    logic ex_t [6], mem_t [6], wb_t [6], use_t [6];
    logic [3:0] rn_t [6];
    logic [1:0] want_t [6];
    ex_t   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    mem_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    wb_t   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    use_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rn_t   = '{4'd4, 4'd4, 4'd15, 4'd4, 4'd4, 4'd4};
    want_t = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00};
    set_idle();
    EX_Rd = 4'd4; MEM_Rd = 4'd4; WB_Rd = 4'd4;
    for (int i = 0; i < 6; i++) begin
      EX_rf = ex_t[i]; MEM_rf = mem_t[i]; WB_rf = wb_t[i];
      ID_Use = {2'b00, use_t[i]}; ID_Rn = rn_t[i];
      exp_q.push_back(model_expect());
      @(negedge CLK);
      got = dut_outs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL fwd_vec%0d: got %b want %b", i, got, exp); end
      vectors++;
      if (FWD_A !== want_t[i]) begin
        miscompares++; $display("FAIL fwd_a_case%0d: got %b want %b", i, FWD_A, want_t[i]);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    logic [11:0] got, exp;
    set_idle();
    EX_Load = 1'b1; EX_Rd = 4'd5; EX_rf = 1'b1; ID_Rm = 4'd5; ID_Use = 3'b010; BR_Taken = 1'b1;
    exp_q.push_back(model_expect());
    @(negedge CLK);
    got = dut_outs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lu_vec: got %b want %b", got, exp); end
    vectors++;
    if ({PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_BUBBLE} !== 5'b00011) begin
      miscompares++; $display("FAIL lu_stall: got %b want 00011", {PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_BUBBLE});
    end
    step();
    EX_Load = 1'b0; EX_rf = 1'b0; MEM_Rd = 4'd5; MEM_rf = 1'b1;
    exp_q.push_back(model_expect());
    @(negedge CLK);
    got = dut_outs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL lu_next_vec: got %b want %b", got, exp); end
    vectors++;
    if (FWD_B !== 2'b10 || IFID_CLR !== 1'b1 || PC_LE !== 1'b1) begin
      miscompares++; $display("FAIL lu_next: got fwd_b=%b clr=%b pc=%b want 10 1 1", FWD_B, IFID_CLR, PC_LE);
    end
    step();
  endtask

  task automatic test_mem_wait();
    logic [11:0] got, exp;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      MEM_BUSY = (i < 3);
      exp_q.push_back(model_expect());
      @(negedge CLK);
      got = dut_outs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL wait_vec%0d: got %b want %b", i, got, exp); end
      vectors++;
      if ({PC_LE, IFID_LE, IDEX_LE, IDEX_BUBBLE, BUS_FAULT} !== ((i < 3) ? 5'b00000 : 5'b11100)) begin
        miscompares++; $display("FAIL wait_ctl%0d: got %b", i, {PC_LE, IFID_LE, IDEX_LE, IDEX_BUBBLE, BUS_FAULT});
      end
      if (i == 2) begin
        vectors++;
        if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL wait_state: got %0d want 1", dbg_state); end
      end
      step();
    end
  endtask

  task automatic test_timeout();
    logic [11:0] got, exp;
    set_idle();
    MEM_BUSY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(model_expect());
      @(negedge CLK);
      got = dut_outs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL timeout_vec%0d: got %b want %b", i, got, exp); end
      vectors++;
      if (BUS_FAULT !== (i >= WAIT_LIMIT) || PC_LE !== 1'b0) begin
        miscompares++; $display("FAIL timeout_fault%0d: got fault=%b pc=%b want %b 0", i, BUS_FAULT, PC_LE, i >= WAIT_LIMIT);
      end
      step();
    end
    MEM_BUSY = 1'b0; BR_Taken = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({BUS_FAULT, PC_LE, IFID_CLR} !== 3'b100) begin
      miscompares++; $display("FAIL fault_sticky: got %b want 100", {BUS_FAULT, PC_LE, IFID_CLR});
    end
    step();
    CLR = 1'b0;
    #1;
    vectors++;
    if ({BUS_FAULT, PC_LE, dbg_state} !== 4'b0100) begin
      miscompares++; $display("FAIL fault_async_clr: got %b want 0100", {BUS_FAULT, PC_LE, dbg_state});
    end
    step();
    CLR = 1'b1;
    exp_q.push_back(model_expect());
    @(negedge CLK);
    got = dut_outs(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL after_clr_vec: got %b want %b", got, exp); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      CLR = !((i % 100) == 90);
      ID_Use = 3'($urandom_range(0, 7));
      ID_Rn = pick_reg(); ID_Rm = pick_reg(); ID_Rs = pick_reg();
      EX_Rd = pick_reg(); MEM_Rd = pick_reg(); WB_Rd = pick_reg();
      EX_rf = 1'($urandom_range(0, 1)); EX_Load = 1'($urandom_range(0, 1));
      MEM_rf = 1'($urandom_range(0, 1)); WB_rf = 1'($urandom_range(0, 1));
      BR_Taken = 1'($urandom_range(0, 1));
      MEM_BUSY = ((i % 100) >= 50 && (i % 100) < 68) || ($urandom_range(0, 5) == 0);
      exp_q.push_back(model_expect());
      @(negedge CLK);
      got = dut_outs(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL rand_vec%0d: got %b want %b", i, got, exp); end
`ifdef STALL_COUNT_EN
      vectors++;
      if (STALL_CNT !== CNT_W'(m_stalls)) begin
        miscompares++; $display("FAIL rand_stall_cnt%0d: got %0d want %0d", i, STALL_CNT, m_stalls);
      end
`endif
      step();
    end
    CLR = 1'b1;
  endtask

`ifdef STALL_COUNT_EN
  task automatic test_stall_count();
    set_idle();
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd5; ID_Rm = 4'd5; ID_Use = 3'b010;
    step();
    set_idle();
    step();
    MEM_BUSY = 1'b1;
    repeat (3) step();
    MEM_BUSY = 1'b0;
    @(negedge CLK);
    vectors++;
    if (STALL_CNT !== 4'd4 || m_stalls != 4) begin
      miscompares++; $display("FAIL stall_cnt_four: got %0d want 4 (model %0d)", STALL_CNT, m_stalls);
    end
    step();
    MEM_BUSY = 1'b1;
    repeat (25) step();
    @(negedge CLK);
    vectors++;
    if (STALL_CNT !== CNT_W'(CNT_MAX)) begin
      miscompares++; $display("FAIL stall_cnt_sat: got %0d want %0d", STALL_CNT, CNT_MAX);
    end
    step();
  endtask
`endif

  initial begin
    set_idle();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
`ifdef STALL_COUNT_EN
    test_stall_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline control for the 5-stage ARM core (IF, ID, EX, MEM, WB).
- Drives load-enables and clears of PC, IF/ID and ID/EX, plus forwarding selects for the three ID/EX register-file operand muxes (ports A, B, C).
- Sequences load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a timeout fault.

Parameters:
- WAIT_LIMIT, 15, max consecutive MEM_BUSY cycles tolerated before fault (1..255).
- CNT_W, 16, width of stall-cycle counter (optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-low reset (0 = reset).
- ID_Rn, ID_Rm, ID_Rs  in  4 each  source registers of instruction in ID (ports A, B, C).
- ID_Use  in  3  valid bits for Rn/Rm/Rs (bit0=A, bit1=B, bit2=C).
- EX_Rd  in  4  ID/EX Rd output.
- EX_rf  in  1  ID/EX register-file write enable.
- EX_Load  in  1  ID/EX load flag.
- MEM_Rd, WB_Rd  in  4 each  destination in MEM / WB.
- MEM_rf, WB_rf  in  1 each  write enables in MEM / WB.
- BR_Taken  in  1  taken branch resolved in ID.
- MEM_BUSY  in  1  data memory not ready.
- PC_LE  out  1  PC load enable.
- IFID_LE  out  1  IF/ID load enable.
- IFID_CLR  out  1  IF/ID flush.
- IDEX_LE  out  1  ID/EX load enable (0 = hold).
- IDEX_BUBBLE  out  1  forces ID/EX control fields to zero next edge.
- FWD_A, FWD_B, FWD_C  out  2 each  00 regfile, 01 EX, 10 MEM, 11 WB.
- BUS_FAULT  out  1  sticky memory-timeout fault.

Behaviour:
- FSM states RUN, MEM_WAIT, FAULT. Reset → RUN, wait counter 0, BUS_FAULT 0.
- During reset: outputs reflect RUN with no hazard (PC_LE=IFID_LE=IDEX_LE=1, flushes 0, FWD=00).
- Forwarding (combinational, every state), per port with Use bit set and source ≠ 15:
  - Match EX_Rd with EX_rf=1 and EX_Load=0 → 01.
  - Otherwise match MEM_Rd with MEM_rf=1 → 10.
  - Otherwise match WB_Rd with WB_rf=1 → 11.
  - Otherwise → 00.
  - Youngest producer wins. Source 15 or Use=0 always gives 00.
- Load-use hazard (LU): EX_Load=1, EX_rf=1, and any used source ≠ 15 equals EX_Rd.
- Priority in RUN:
  1. MEM_BUSY=1: freeze. PC_LE=IFID_LE=IDEX_LE=0, no bubble, no flush. Go to MEM_WAIT, counter=1.
  2. LU: PC_LE=IFID_LE=0, IDEX_BUBBLE=1, IDEX_LE=1. Exactly one stall cycle; next cycle the load is in MEM and forwards via 10.
  3. BR_Taken and no LU: IFID_CLR=1, all LE=1.
  4. Otherwise: all LE=1, clears 0.
- LU and BR_Taken together: stall only. Branch is re-evaluated next cycle because ID holds.
- MEM_WAIT:
  - Full freeze every cycle; counter increments per busy cycle.
  - MEM_BUSY=0: return to RUN and apply RUN rules combinationally that same cycle.
  - Counter reaching WAIT_LIMIT with MEM_BUSY still 1: go to FAULT.
  - The counter is 8 bits, saturating.
- FAULT:
  - Full freeze and BUS_FAULT=1 until CLR.
  - MEM_BUSY, BR_Taken and LU are ignored.
- Reset asserted in any state: immediate return to RUN; counter and fault cleared asynchronously.
- The only registered elements are the state, the wait counter and the optional counter. All LE/CLR/FWD outputs are combinational from state and inputs.

Optional Feature:
- STALL_COUNT_EN defined:
  - Adds output STALL_CNT [CNT_W-1:0].
  - Increments on each cycle with PC_LE=0 (LU, MEM_WAIT, FAULT, RUN-busy entry).
  - Saturates at all-ones; reset to 0 by CLR.
- STALL_COUNT_EN undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset release, no hazards, ID_Use=111 with sources 1,2,3 and producers with other Rd → all LE=1, FWD_A/B/C=00, BUS_FAULT=0.
- EX_Rd=4, EX_rf=1, EX_Load=0, MEM_Rd=4, MEM_rf=1, ID_Rn=4 → FWD_A=01. With EX_rf=0 → FWD_A=10. ID_Rn=15 → 00.
- EX_Load=1, EX_Rd=5, EX_rf=1, ID_Rm=5, BR_Taken=1 → one cycle of PC_LE=IFID_LE=0, IDEX_BUBBLE=1, IFID_CLR=0. Next cycle with load in MEM (MEM_Rd=5) → FWD_B=10; IFID_CLR=1 if BR_Taken still 1.
- MEM_BUSY high 3 cycles, WAIT_LIMIT=15 → 3 frozen cycles (all LE=0, no bubble), then RUN resumes; BUS_FAULT stays 0.
- MEM_BUSY held high → BUS_FAULT=1 after 15 busy cycles and stays high when MEM_BUSY drops. CLR pulse low mid-fault → immediate RUN, BUS_FAULT=0.
- With STALL_COUNT_EN: one LU stall plus a 3-cycle wait → STALL_CNT=4. Counter preset near all-ones saturates and does not wrap.
